// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: one full-adder cell and a carry flop add a+b LSB
// first over WIDTH cycles, then pulse done for one cycle with sum/cout valid.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       w_fa;

  // Full adder as two cascaded half adders; returns {carry, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic cin);
    logic ha1_s;
    logic ha1_c;
    logic ha2_s;
    logic ha2_c;
    ha1_s = x ^ y;
    ha1_c = x & y;
    ha2_s = ha1_s ^ cin;
    ha2_c = ha1_s & cin;
    return {ha1_c | ha2_c, ha2_s};
  endfunction

  assign w_fa = full_add(r_a[0], r_b[0], r_carry);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          // Sum bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_sum   <= {w_fa[0], r_sum[WIDTH-1:1]};
          r_carry <= w_fa[1];
          if (r_cnt == LAST_BIT) begin
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_carry;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: expected {cout,sum} is queued at each
// accepted start and compared at every done pulse.
module tb_serial_adder;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  int total = 0;
  int bad   = 0;
  logic [WIDTH:0] sb[$];

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    return {1'b0, x} + {1'b0, y};
  endfunction

  // Scoreboard consumer: every done pulse must match the oldest queued result.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 32'(done), 32'd0);
      end else begin
        logic [WIDTH:0] exp;
        exp = sb.pop_front();
        chk("sum", 32'(sum), 32'(exp[WIDTH-1:0]));
        chk("cout", 32'(cout), 32'(exp[WIDTH]));
      end
    end
  end

  task automatic run_one(input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb);
    a = aa;
    b = bb;
    start = 1'b1;
    sb.push_back(ref_add(aa, bb));
    tick();
    start = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      chk("busy_run", 32'(busy), 32'd1);
      chk("done_run", 32'(done), 32'd0);
      tick();
    end
    chk("busy_at_done", 32'(busy), 32'd0);
    chk("done_pulse", 32'(done), 32'd1);
    tick();
    chk("done_low", 32'(done), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  task automatic b2b(input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb);
    a = aa;
    b = bb;
    start = 1'b1;
    sb.push_back(ref_add(aa, bb));
    tick();
    repeat (WIDTH) tick();
    chk("b2b_done", 32'(done), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [WIDTH-1:0] corners[6];
    corners = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFE, 8'hFF};
    rst_n = 1'b0;
    start = 1'b1;
    a = 8'h12;
    b = 8'h34;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);

    // First edge with rst_n high accepts the start.
    rst_n = 1'b1;
    run_one(8'h00, 8'h00);
    run_one(8'h5A, 8'h25);
    run_one(8'hFF, 8'h01);
    run_one(8'hFF, 8'hFF);

    repeat (3) tick();
    chk("hold_sum", 32'(sum), 32'hFE);
    chk("hold_cout", 32'(cout), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("idle_rst_sum", 32'(sum), 32'd0);
    chk("idle_rst_cout", 32'(cout), 32'd0);
    tick();

    // Start held through RUN is ignored, then relaunches from the DONE cycle.
    a = 8'h0F;
    b = 8'h01;
    start = 1'b1;
    sb.push_back(ref_add(8'h0F, 8'h01));
    tick();
    a = 8'hAA;
    b = 8'h55;
    sb.push_back(ref_add(8'hAA, 8'h55));
    for (int i = 0; i < WIDTH; i++) begin
      chk("hs_busy", 32'(busy), 32'd1);
      tick();
    end
    chk("hs_done1", 32'(done), 32'd1);
    tick();
    start = 1'b0;
    chk("hs_relaunch_busy", 32'(busy), 32'd1);
    chk("hs_relaunch_done", 32'(done), 32'd0);
    repeat (WIDTH) tick();
    chk("hs_done2", 32'(done), 32'd1);
    tick();

    // Reset on the 4th RUN edge aborts the operation with no done pulse.
    a = 8'h80;
    b = 8'h80;
    start = 1'b1;
    sb.push_back(ref_add(8'h80, 8'h80));
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    sb.delete();
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    for (int i = 0; i < WIDTH + 2; i++) begin
      chk("abort_no_done", 32'(done), 32'd0);
      tick();
    end
    run_one(8'h80, 8'h80);

    // Back-to-back sweep: strided grid, corner pairs, then random operands.
    for (int i = 0; i < 256; i += 17)
      for (int j = 0; j < 256; j += 17)
        b2b(WIDTH'(i), WIDTH'(j));
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6; j++)
        b2b(corners[i], corners[j]);
    for (int k = 0; k < 1500; k++)
      b2b(WIDTH'($urandom_range(0, 255)), WIDTH'($urandom_range(0, 255)));
    start = 1'b0;
    tick();
    chk("sweep_idle", 32'(busy), 32'd0);
    repeat (3) tick();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
